fir_tap_feeder: RTL and testbench
=================================

Name: fir_tap_feeder

Overview:
- Upstream stage of the 10-tap FIR product/accumulate block.
- Turns a serial sample stream into the parallel 10-sample window x0..x9.
- Holds the 10 coefficients h0..h9, written through a small write port.
- Pulses win_valid when a fresh, fully primed window is presented, so the downstream block sees it at its next rising edge.

Parameters:
- n, 4, sample and coefficient width in bits (matches the downstream n).
- ZERO_PRIME, 0, 1 = treat the empty delay line as zeros and assert win_valid from the first sample; 0 = wait for 10 real samples.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  sample strobe; s_data is accepted on any posedge with s_valid=1.
- s_data  in  n  input sample.
- flush  in  1  clears the delay line and fill count; coefficients are kept.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  4  coefficient index 0..9.
- coef_data  in  n  coefficient value.
- x0..x9  out  n each  delay-line window; x0 = newest sample, x9 = oldest; registered.
- h0..h9  out  n each  coefficient registers; registered.
- win_valid  out  1  one-cycle pulse: x0..x9 hold a new complete window.
- fill_cnt  out  4  number of real samples in the line, saturating at 10.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - x0..x9 = 0, h0..h9 = 0, win_valid = 0, fill_cnt = 0.
  - State = FILL (ZERO_PRIME=0) or RUN (ZERO_PRIME=1).
- Sample accept, s_valid=1 and flush=0:
  - Shift x9<=x8, ..., x1<=x0, x0<=s_data.
  - fill_cnt <= min(fill_cnt+1, 10).
- State machine (2 states):
  - FILL: win_valid=0. The transition to RUN happens on the accept that makes fill_cnt reach 10, and win_valid=1 in that same update, so it is aligned with the 10th sample appearing on x0.
  - RUN: every accept sets win_valid=1 for exactly one cycle; cycles without an accept have win_valid=0.
  - Back-to-back accepts give win_valid high continuously.
- Latency: a sample on s_data at edge k is on x0 after edge k, with win_valid qualifying it in that cycle; it is on x9 after 9 further accepts.
- Flush:
  - x0..x9 = 0, fill_cnt = 0, win_valid = 0.
  - State = FILL (ZERO_PRIME=0) or stays RUN (ZERO_PRIME=1).
  - flush and s_valid in the same cycle: flush wins and the sample is dropped.
- Coefficient write:
  - coef_we=1 with coef_addr<=9: h[coef_addr] <= coef_data on that edge.
  - coef_addr 10..15: write ignored, no state change.
  - Writes are independent of the sample path; a simultaneous write and accept both take effect on the same edge.
  - Coefficients survive flush; only rst clears them.
- Saturation: fill_cnt never exceeds 10 and never wraps; further accepts leave it at 10.
- Width: no arithmetic on data; samples and coefficients pass through bit-exact.
- Reset mid-stream: all outputs return to reset values immediately (async); the next accept after release is treated as sample #1.

Decomposition:
- Package fir_pkg holds:
  - TAPS = 10.
  - FILL_W = 4 (fill_cnt width).
  - COEF_ADDR_W = 4.
  - State enum {FILL, RUN}.
- Sub-module fir_coef_bank: 10 x n register file with write port (we/addr/data), address range check and async reset; exposes h0..h9 flat.
- The delay line, fill counter and FSM stay in fir_tap_feeder.

Test Plan:
- Reset then idle 5 cycles -> all x, h = 0; win_valid = 0; fill_cnt = 0.
- Write h[i] = i+1 for i = 0..9, then coef_addr = 12 with coef_data = 0xF -> h0..h9 = 1..10, no other change.
- ZERO_PRIME=0, accept samples 1..10 on consecutive cycles -> win_valid first high with x0=10, x9=1; fill_cnt = 10; then sample 11 -> x0=11, x9=2, win_valid high.
- Samples with 2-cycle gaps in RUN -> win_valid is a one-cycle pulse per accept, 0 in the gaps.
- flush together with s_valid (s_data=7) after 6 samples -> x all 0, fill_cnt = 0, win_valid = 0, h unchanged; 7 not captured.
- ZERO_PRIME=1, single sample 5 after reset -> win_valid = 1, x0 = 5, x1..x9 = 0, fill_cnt = 1.
- Assert rst asynchronously mid-stream -> outputs zero before the next posedge.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state type for the FIR tap feeder.
package fir_pkg;

  localparam int TAPS        = 10;
  localparam int FILL_W      = 4;
  localparam int COEF_ADDR_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: TAPS entries of n bits with a single write port.
// Addresses outside 0..TAPS-1 are dropped without touching any entry.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int n = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [COEF_ADDR_W-1:0] addr,
  input  logic [n-1:0]           data,
  output logic [TAPS*n-1:0]      h_flat
);

  logic addr_ok;
  assign addr_ok = (addr < COEF_ADDR_W'(TAPS));

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
      logic [n-1:0] h_q;

      // Load this coefficient when the write targets its index.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          h_q <= '0;
        end else if (we && addr_ok && (addr == COEF_ADDR_W'(gi))) begin
          h_q <= data;
        end
      end

      assign h_flat[gi*n +: n] = h_q;
    end
  endgenerate

endmodule

// File: rtl/fir_tap_feeder.sv
// Serial-to-parallel window builder for the 10-tap FIR: delay line, fill
// counter and a FILL/RUN machine that pulses win_valid on each fresh window.
module fir_tap_feeder
  import fir_pkg::*;
#(
  parameter int n          = 4,
  parameter int ZERO_PRIME = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [n-1:0]           s_data,
  input  logic                   flush,
  input  logic                   coef_we,
  input  logic [COEF_ADDR_W-1:0] coef_addr,
  input  logic [n-1:0]           coef_data,
  output logic [n-1:0]           x0, x1, x2, x3, x4, x5, x6, x7, x8, x9,
  output logic [n-1:0]           h0, h1, h2, h3, h4, h5, h6, h7, h8, h9,
  output logic                   win_valid,
  output logic [FILL_W-1:0]      fill_cnt
);

  // With zero priming the empty line already counts as a valid window.
  localparam state_t IDLE_STATE = (ZERO_PRIME != 0) ? RUN : FILL;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(TAPS);

  logic [n-1:0]      x_q [TAPS];
  logic [n-1:0]      x_d [TAPS];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              win_valid_q, win_valid_d;
  state_t            state_q, state_d;
  logic              accept;
  logic [TAPS*n-1:0] h_flat;

  // Flush has priority: a sample arriving with flush is dropped.
  assign accept = s_valid && !flush;

  // Delay line next state: clear on flush, shift newest into slot 0 on accept.
  always_comb begin
    x_d = x_q;
    if (flush) begin
      for (int i = 0; i < TAPS; i++) x_d[i] = '0;
    end else if (accept) begin
      for (int i = TAPS - 1; i > 0; i--) x_d[i] = x_q[i-1];
      x_d[0] = s_data;
    end
  end

  // Fill counter, FSM transition and win_valid pulse.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    win_valid_d = 1'b0;
    if (flush) begin
      fill_d  = '0;
      state_d = IDLE_STATE;
    end else if (accept) begin
      fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      unique case (state_q)
        FILL: begin
          // The accept that brings the line to full both enters RUN and
          // qualifies that window, aligned with the 10th sample on x0.
          if (fill_q == FULL - 1'b1) begin
            state_d     = RUN;
            win_valid_d = 1'b1;
          end
        end
        RUN: win_valid_d = 1'b1;
        default: state_d = IDLE_STATE;
      endcase
    end
  end

  // Register the sample path and control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      fill_q      <= '0;
      win_valid_q <= 1'b0;
      state_q     <= IDLE_STATE;
    end else begin
      x_q         <= x_d;
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
      state_q     <= state_d;
    end
  end

  fir_coef_bank #(.n(n)) u_coef_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (coef_we),
    .addr   (coef_addr),
    .data   (coef_data),
    .h_flat (h_flat)
  );

  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];
  assign x4 = x_q[4];
  assign x5 = x_q[5];
  assign x6 = x_q[6];
  assign x7 = x_q[7];
  assign x8 = x_q[8];
  assign x9 = x_q[9];

  assign h0 = h_flat[0*n +: n];
  assign h1 = h_flat[1*n +: n];
  assign h2 = h_flat[2*n +: n];
  assign h3 = h_flat[3*n +: n];
  assign h4 = h_flat[4*n +: n];
  assign h5 = h_flat[5*n +: n];
  assign h6 = h_flat[6*n +: n];
  assign h7 = h_flat[7*n +: n];
  assign h8 = h_flat[8*n +: n];
  assign h9 = h_flat[9*n +: n];

  assign win_valid = win_valid_q;
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Bench for fir_tap_feeder: one instance without and one with zero priming,
// driven by the same stimulus and compared against a window/queue model.
module tb_fir_tap_feeder;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic [N-1:0] s_data;
  logic         flush;
  logic         coef_we;
  logic [3:0]   coef_addr;
  logic [N-1:0] coef_data;

  logic [N-1:0] xa [10];
  logic [N-1:0] ha [10];
  logic [N-1:0] xb [10];
  logic [N-1:0] hb [10];
  logic         wva, wvb;
  logic [3:0]   fa, fb;

  int n_checks = 0;
  int n_errors = 0;
  int txn      = 0;

  // Reference model: window newest-first, count of real samples, coefficients.
  int m_win  [10];
  int m_coef [10];
  int m_fill;
  bit m_acc;

  always #5 clk = ~clk;

  fir_tap_feeder #(.n(N), .ZERO_PRIME(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .x4(xa[4]),
    .x5(xa[5]), .x6(xa[6]), .x7(xa[7]), .x8(xa[8]), .x9(xa[9]),
    .h0(ha[0]), .h1(ha[1]), .h2(ha[2]), .h3(ha[3]), .h4(ha[4]),
    .h5(ha[5]), .h6(ha[6]), .h7(ha[7]), .h8(ha[8]), .h9(ha[9]),
    .win_valid(wva), .fill_cnt(fa)
  );

  fir_tap_feeder #(.n(N), .ZERO_PRIME(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]),
    .x5(xb[5]), .x6(xb[6]), .x7(xb[7]), .x8(xb[8]), .x9(xb[9]),
    .h0(hb[0]), .h1(hb[1]), .h2(hb[2]), .h3(hb[3]), .h4(hb[4]),
    .h5(hb[5]), .h6(hb[6]), .h7(hb[7]), .h8(hb[8]), .h9(hb[9]),
    .win_valid(wvb), .fill_cnt(fb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_win[i]  = 0;
      m_coef[i] = 0;
    end
    m_fill = 0;
    m_acc  = 1'b0;
  endtask

  task automatic model_step();
    if (coef_we && coef_addr < 10) m_coef[coef_addr] = int'(coef_data);
    m_acc = 1'b0;
    if (flush) begin
      for (int i = 0; i < 10; i++) m_win[i] = 0;
      m_fill = 0;
    end else if (s_valid) begin
      for (int i = 9; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = int'(s_data);
      m_fill   = (m_fill + 1 > 10) ? 10 : m_fill + 1;
      m_acc    = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [39:0] exp_x, got_xa, got_xb, exp_h, got_ha, got_hb;
    for (int i = 0; i < 10; i++) begin
      exp_x[i*4 +: 4]  = 4'(m_win[i]);
      exp_h[i*4 +: 4]  = 4'(m_coef[i]);
      got_xa[i*4 +: 4] = xa[i];
      got_xb[i*4 +: 4] = xb[i];
      got_ha[i*4 +: 4] = ha[i];
      got_hb[i*4 +: 4] = hb[i];
    end
    check({tag, "_x_zp0"}, 64'(got_xa), 64'(exp_x));
    check({tag, "_x_zp1"}, 64'(got_xb), 64'(exp_x));
    check({tag, "_h_zp0"}, 64'(got_ha), 64'(exp_h));
    check({tag, "_h_zp1"}, 64'(got_hb), 64'(exp_h));
    check({tag, "_fill_zp0"}, 64'(fa), 64'(m_fill));
    check({tag, "_fill_zp1"}, 64'(fb), 64'(m_fill));
    check({tag, "_wv_zp0"}, 64'(wva), 64'(m_acc && m_fill == 10));
    check({tag, "_wv_zp1"}, 64'(wvb), 64'(m_acc));
  endtask

  // One clocked transaction: drive, clock, update model, check after the edge.
  task automatic cycle(input string tag, input logic sv, input int sd, input logic fl,
                       input logic we, input int addr, input int data);
    s_valid   = sv;
    s_data    = N'(sd);
    flush     = fl;
    coef_we   = we;
    coef_addr = 4'(addr);
    coef_data = N'(data);
    @(posedge clk);
    model_step();
    #1;
    txn++;
    check_all(tag);
    $display("txn %0d %s sv=%0b d=%0h fl=%0b we=%0b a=%0d x0=%0h x9=%0h fill=%0d wv=%0b/%0b",
             txn, tag, sv, s_data, fl, we, addr, xa[0], xa[9], fa, wva, wvb);
  endtask

  initial begin
    rst = 1'b1; s_valid = 0; s_data = 0; flush = 0;
    coef_we = 0; coef_addr = 0; coef_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cycle("idle", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) cycle("coef_wr", 0, 0, 0, 1, i, i + 1);
    cycle("coef_oob", 0, 0, 0, 1, 12, 15);

    // Priming: samples 1..10, then 11.
    for (int i = 1; i <= 10; i++) cycle("prime", 1, i, 0, 0, 0, 0);
    check("first_win_x0", 64'(xa[0]), 64'(10));
    check("first_win_x9", 64'(xa[9]), 64'(1));
    check("first_win_wv", 64'(wva), 64'(1));
    cycle("s11", 1, 11, 0, 0, 0, 0);
    check("s11_x9", 64'(xa[9]), 64'(2));

    // Gapped accepts in RUN.
    for (int i = 0; i < 4; i++) begin
      cycle("gap_acc", 1, 12 + i, 0, 0, 0, 0);
      cycle("gap_idle", 0, 0, 0, 0, 0, 0);
      cycle("gap_idle", 0, 0, 0, 0, 0, 0);
    end

    // Flush, six samples, then flush colliding with a sample.
    cycle("flush", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("six", 1, i + 3, 0, 0, 0, 0);
    cycle("flush_sv", 1, 7, 1, 0, 0, 0);
    check("flush_drop_x0", 64'(xa[0]), 64'(0));
    check("flush_keep_h9", 64'(ha[9]), 64'(10));

    // Randomized traffic, including simultaneous writes and accepts.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 99) < 65),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 4),
            ($urandom_range(0, 99) < 20),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-stream: outputs clear before the next edge.
    cycle("pre_arst", 1, 9, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    s_valid = 0; flush = 0; coef_we = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First accept after reset: zero-primed instance qualifies immediately.
    cycle("zp_first", 1, 5, 0, 0, 0, 0);
    check("zp1_wv", 64'(wvb), 64'(1));
    check("zp1_x0", 64'(xb[0]), 64'(5));
    check("zp1_fill", 64'(fb), 64'(1));
    check("zp0_wv", 64'(wva), 64'(0));
    for (int i = 0; i < 12; i++) cycle("post", 1, i, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
